serial_subtractor: RTL



---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: computes a - b - bin and the outgoing borrow.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Single-bit difference and borrow-out
    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    sub_state_t       r_state;
    sub_state_t       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_bout;
    logic             w_last;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;
    assign ovf = r_ovf;
`endif

    assign d      = r_res;
    assign borrow = r_borrow;
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    full_subtractor u_fs (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .diff (w_diff),
        .bout (w_bout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operand capture, serial shift datapath, borrow flop and step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    r_a      <= {1'b0, r_a[WIDTH-1:1]};
                    r_b      <= {1'b0, r_b[WIDTH-1:1]};
                    r_res    <= {w_diff, r_res[WIDTH-1:1]};
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CNT_W'(1);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    // Last step's diff bit is the result MSB
                    if (w_last) begin
                        r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_diff);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
